// File: rtl/frame_deframer.sv
`default_nettype none
// ============================================================================
// Module   : frame_deframer
// Brief    : Recovers M8 frame alignment from the word-0 marker bit, tags each
//            word with word/phrase/group indices and tracks lock with a
//            flywheel. Optional macro GRPNUM_CHECK_EN compares the decoded group
//            number against the flywheel while locked.
// Revision : 1.0 - initial release
// ============================================================================
module frame_deframer #(
    parameter int CONFIRM_N = 2,
    parameter int MISS_N    = 3,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [11:0]      iData,
    input  logic             iValid,
    output logic [11:0]      oData,
    output logic             oValid,
    output logic [2:0]       oWrd,
    output logic [6:0]       oPhr,
    output logic [4:0]       oGrp,
    output logic             oLock,
    output logic             oCycStart,
    output logic [ERR_W-1:0] oErrCnt
);

    localparam int c_CONF_W = $clog2(CONFIRM_N + 1);
    localparam int c_MISS_W = $clog2(MISS_N + 1);
    localparam logic [c_CONF_W-1:0] c_CONF_LAST = c_CONF_W'(CONFIRM_N - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_N - 1);
    // Odd-phrase sync patterns, bit j = phrase 113+2j
    localparam logic [7:0] c_NORMAL = 8'b0100_1110;
    localparam logic [7:0] c_CYCLE  = 8'b1011_0001;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    state_t              r_state, w_nState;
    logic [119:0]        r_shift;
    logic [120:0]        w_window;
    logic [7:0]          w_odd, w_even;
    logic                w_isNormal, w_isCycle;
    logic [4:0]          w_decGrp;
    logic [2:0]          r_wrd, w_incWrd, w_nWrd;
    logic [6:0]          r_phr, w_incPhr, w_nPhr;
    logic [4:0]          r_grp, w_incGrp, w_nGrp;
    logic [c_CONF_W-1:0] r_confirm, w_nConfirm;
    logic [c_MISS_W-1:0] r_miss, w_nMiss;
    logic                w_errInc, w_missEvt, w_word0;
    logic [11:0]         r_data;
    logic                r_valid, r_cycStart;
    logic [ERR_W-1:0]    r_errCnt;

    // Marker history ends at the oldest tap (120 words back); bit 0 is the current word
    assign w_window = {r_shift, iData[11]};

    for (genvar j = 0; j < 8; j++) begin : g_taps
        assign w_odd[j]  = w_window[8*(14-2*j)];
        assign w_even[j] = w_window[8*(2*j+1)];
    end

    assign w_isNormal = (&w_even) && (w_odd == c_NORMAL);
    assign w_isCycle  = (&w_even) && (w_odd == c_CYCLE);
    // Group number bits sit on phrases 5,7,9,11,13 relative to a phrase-13 word
    assign w_decGrp   = {w_window[64], w_window[48], w_window[32], w_window[16], w_window[0]};

    assign w_incWrd = r_wrd + 3'd1;
    assign w_incPhr = (r_wrd == 3'd7) ? r_phr + 7'd1 : r_phr;
    assign w_incGrp = (r_wrd == 3'd7 && r_phr == 7'd127) ? r_grp + 5'd1 : r_grp;
    assign w_word0  = (w_incWrd == 3'd0);

    always_comb begin
        w_nState   = r_state;
        w_nWrd     = r_wrd;
        w_nPhr     = r_phr;
        w_nGrp     = r_grp;
        w_nConfirm = r_confirm;
        w_nMiss    = r_miss;
        w_errInc   = 1'b0;
        w_missEvt  = 1'b0;
        if (iValid) begin
            w_nWrd = w_incWrd;
            w_nPhr = w_incPhr;
            w_nGrp = w_incGrp;
            unique case (r_state)
                S_SEARCH: begin
                    if (w_isNormal || w_isCycle) begin
                        w_nWrd     = 3'd0;
                        w_nPhr     = 7'd127;
                        w_nGrp     = w_isCycle ? 5'd31 : 5'd0;
                        w_nConfirm = c_CONF_W'(1);
                        w_nMiss    = '0;
                        w_nState   = (CONFIRM_N <= 1) ? S_LOCK : S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_word0 && w_incPhr == 7'd13) begin
                        w_nGrp = w_decGrp;
                    end
                    if (w_word0 && w_incPhr == 7'd127) begin
                        if (w_isNormal || w_isCycle) begin
                            if (w_isCycle) begin
                                w_nGrp = 5'd31;
                            end
                            w_nConfirm = r_confirm + 1'b1;
                            if (r_confirm >= c_CONF_LAST) begin
                                w_nState = S_LOCK;
                                w_nMiss  = '0;
                            end
                        end else begin
                            w_nState = S_SEARCH;
                        end
                    end
                end
                S_LOCK: begin
                    if (w_word0) begin
                        if (w_incPhr == 7'd13) begin
                            w_nGrp = w_decGrp;
`ifdef GRPNUM_CHECK_EN
                            if (w_decGrp != w_incGrp) begin
                                w_errInc  = 1'b1;
                                w_missEvt = 1'b1;
                            end
`endif
                        end
                        if (w_incPhr == 7'd127) begin
                            if ((w_isNormal && w_incGrp != 5'd31) ||
                                (w_isCycle && w_incGrp == 5'd31)) begin
                                w_nMiss = '0;
                            end else begin
                                w_missEvt = 1'b1;
                            end
                        end
                        if ((!w_incPhr[0] && !iData[11]) ||
                            ((w_incPhr == 7'd1 || w_incPhr == 7'd3) && iData[11])) begin
                            w_errInc = 1'b1;
                        end
                        if (w_missEvt) begin
                            if (r_miss >= c_MISS_LAST) begin
                                w_nState = S_SEARCH;
                                w_nMiss  = '0;
                            end else begin
                                w_nMiss = r_miss + 1'b1;
                            end
                        end
                    end
                end
                default: w_nState = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_SEARCH;
            r_shift    <= '0;
            r_wrd      <= '0;
            r_phr      <= '0;
            r_grp      <= '0;
            r_confirm  <= '0;
            r_miss     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_cycStart <= 1'b0;
            r_errCnt   <= '0;
        end else begin
            r_state    <= w_nState;
            r_wrd      <= w_nWrd;
            r_phr      <= w_nPhr;
            r_grp      <= w_nGrp;
            r_confirm  <= w_nConfirm;
            r_miss     <= w_nMiss;
            r_valid    <= iValid;
            r_cycStart <= iValid && (w_nState == S_LOCK) &&
                          (w_nWrd == 3'd0) && (w_nPhr == 7'd0) && (w_nGrp == 5'd0);
            if (iValid) begin
                r_data  <= iData;
                r_shift <= w_window[119:0];
            end
            if (w_errInc && r_errCnt != {ERR_W{1'b1}}) begin
                r_errCnt <= r_errCnt + 1'b1;
            end
        end
    end

    assign oData     = r_data;
    assign oValid    = r_valid;
    assign oWrd      = r_wrd;
    assign oPhr      = r_phr;
    assign oGrp      = r_grp;
    assign oLock     = (r_state == S_LOCK);
    assign oCycStart = r_cycStart;
    assign oErrCnt   = r_errCnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_deframer
// Brief    : Directed M8 stream stimulus with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] iData;
    logic        iValid;
    logic [11:0] oData;
    logic        oValid;
    logic [2:0]  oWrd;
    logic [6:0]  oPhr;
    logic [4:0]  oGrp;
    logic        oLock;
    logic        oCycStart;
    logic [15:0] oErrCnt;

    int total = 0;
    int bad   = 0;
    int curG, curP, curW;
    logic [31:0] badMask;
    int ovGrp, ovVal, corG, corP;

    frame_deframer #(.CONFIRM_N(2), .MISS_N(3), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .iData(iData), .iValid(iValid),
        .oData(oData), .oValid(oValid), .oWrd(oWrd), .oPhr(oPhr), .oGrp(oGrp),
        .oLock(oLock), .oCycStart(oCycStart), .oErrCnt(oErrCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word-0 marker bit of phrase p in group g, including injected faults
    function automatic logic markerBit(input int g, input int p);
        logic pat [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int gb;
        gb = (g == ovGrp) ? ovVal : g;
        if (g == corG && p == corP) return 1'b0;
        if (p % 2 == 0) return 1'b1;
        if (p >= 5 && p <= 13) return 1'((gb >> (4 - (p - 5) / 2)) & 1);
        if (p >= 113) begin
            if (badMask[g]) return 1'b0;
            return (g == 31) ? ~pat[(p - 113) / 2] : pat[(p - 113) / 2];
        end
        return 1'b0;
    endfunction

    function automatic logic [11:0] wordFor(input int g, input int p, input int w);
        logic [10:0] lo;
        lo = 11'(g * 37 + p * 5 + w * 3);
        return {(w == 0) ? markerBit(g, p) : 1'b0, lo};
    endfunction

    task automatic sendWord(input logic [11:0] d);
        repeat (4) @(posedge clk);
        #1;
        iData  = d;
        iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
    endtask

    // Stream from the current position up to and including word (g,p,w)
    task automatic goTo(input int g, input int p, input int w);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            sendWord(wordFor(curG, curP, curW));
            done = (curG == g && curP == p && curW == w);
            curW = curW + 1;
            if (curW == 8) begin
                curW = 0;
                curP = curP + 1;
                if (curP == 128) begin
                    curP = 0;
                    curG = (curG + 1) % 32;
                end
            end
            n++;
            if (!done && n > 40000) begin
                total++;
                bad++;
                $error("FAIL goto: target %0d/%0d/%0d not reached, got %0d/%0d/%0d",
                       g, p, w, curG, curP, curW);
                done = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        iValid  = 1'b0;
        iData   = '0;
        badMask = '0;
        ovGrp   = -1;
        ovVal   = 0;
        corG    = -1;
        corP    = -1;
        curG = 0; curP = 0; curW = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst oValid", 32'(oValid), 32'd0);
        check("rst oData", 32'(oData), 32'd0);
        check("rst oLock", 32'(oLock), 32'd0);
        check("rst oErrCnt", 32'(oErrCnt), 32'd0);
        check("rst tags", {17'd0, oGrp, oPhr, oWrd}, 32'd0);
        check("rst oCycStart", 32'(oCycStart), 32'd0);

        // Acquisition from group 0 phrase 0
        goTo(0, 127, 0);
        check("acq match oLock", 32'(oLock), 32'd0);
        check("acq match tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd0, 7'd127, 3'd0});
        check("acq oData", 32'(oData), 32'(wordFor(0, 127, 0)));
        check("acq oValid", 32'(oValid), 32'd1);
        goTo(1, 126, 7);
        check("check not locked", 32'(oLock), 32'd0);
        goTo(1, 127, 0);
        check("lock oLock", 32'(oLock), 32'd1);
        check("lock tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd1, 7'd127, 3'd0});

        // Marker error on even phrase
        corG = 2; corP = 4;
        goTo(2, 3, 0);
        check("pre-err cnt", 32'(oErrCnt), 32'd0);
        goTo(2, 4, 0);
        check("err cnt", 32'(oErrCnt), 32'd1);
        check("err lock held", 32'(oLock), 32'd1);
        goTo(2, 13, 1);
        check("grp2 tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd2, 7'd13, 3'd1});

        // Two bad windows then good, then three bad
        badMask = 32'h0000_01D8;  // groups 3,4,6,7,8
        goTo(4, 127, 0);
        check("2 miss lock held", 32'(oLock), 32'd1);
        goTo(5, 127, 0);
        check("good window lock", 32'(oLock), 32'd1);
        goTo(7, 127, 0);
        check("2nd miss lock held", 32'(oLock), 32'd1);
        goTo(8, 127, 0);
        check("3rd miss drops lock", 32'(oLock), 32'd0);
        check("3rd miss oValid", 32'(oValid), 32'd1);
        check("err cnt kept", 32'(oErrCnt), 32'd1);
        badMask = '0;

        // Reset mid-frame, restart mid-group
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst oErrCnt", 32'(oErrCnt), 32'd0);
        check("midrst oLock", 32'(oLock), 32'd0);
        curG = 5; curP = 60; curW = 5;
        goTo(5, 126, 7);
        check("mid no lock", 32'(oLock), 32'd0);
        goTo(5, 127, 0);
        check("mid match tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd0, 7'd127, 3'd0});
        goTo(6, 13, 0);
        check("mid decode grp", 32'(oGrp), 32'd6);
        goTo(6, 127, 0);
        check("mid lock", 32'(oLock), 32'd1);
        goTo(7, 0, 3);
        check("mid tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd7, 7'd0, 3'd3});

        // Group 7 carries group number 9
        ovGrp = 7; ovVal = 9;
        goTo(7, 13, 0);
        check("grpnum oGrp", 32'(oGrp), 32'd9);
`ifdef GRPNUM_CHECK_EN
        check("grpnum err", 32'(oErrCnt), 32'd1);
`else
        check("grpnum err", 32'(oErrCnt), 32'd0);
`endif
        check("grpnum lock", 32'(oLock), 32'd1);
        goTo(7, 14, 0);
        check("grpnum oGrp next", 32'(oGrp), 32'd9);
        ovGrp = -1;

        // Cycle start across group 31 -> 0
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        curG = 30; curP = 100; curW = 0;
        goTo(30, 127, 0);
        check("g30 match grp", 32'(oGrp), 32'd0);
        goTo(31, 13, 0);
        check("g31 decode", 32'(oGrp), 32'd31);
        goTo(31, 127, 0);
        check("g31 lock", 32'(oLock), 32'd1);
        check("g31 tags", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd31, 7'd127, 3'd0});
        check("g31 no cyc", 32'(oCycStart), 32'd0);
        goTo(0, 0, 0);
        check("cyc start", 32'(oCycStart), 32'd1);
        check("cyc tags", {17'd0, oGrp, oPhr, oWrd}, 32'd0);
        goTo(0, 0, 1);
        check("cyc single", 32'(oCycStart), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("idle oValid", 32'(oValid), 32'd0);
        check("idle oData hold", 32'(oData), 32'(wordFor(0, 0, 1)));
        check("idle tags hold", {17'd0, oGrp, oPhr, oWrd}, {17'd0, 5'd0, 7'd0, 3'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
